// File: rtl/ysyx_23060061_axi_pkg.sv
// Shared AXI-Lite definitions: response codes, FSM encodings, address decode.
package ysyx_23060061_axi_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned RND_W       = 3;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_WAIT = 2'b01,
    R_RESP = 2'b10
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_WAIT = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  // Misaligned, below base, or past the last word -> decode error
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || (addr < base) || (((addr - base) >> 2) >= depth);
  endfunction

endpackage

// File: rtl/ysyx_23060061_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5, free-running.
// Only built when YSYX_23060061_SRAM_RAND_DELAY_EN is defined.
`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
module ysyx_23060061_lfsr8
  import ysyx_23060061_axi_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [RND_W-1:0] rnd_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feedback taps at bits 8,6,5,4
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // State register, reseeded on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q[RND_W-1:0];

endmodule
`endif

// File: rtl/ysyx_23060061_axil_sram.sv
// AXI-Lite word SRAM with independent read and write FSMs.
// YSYX_23060061_SRAM_RAND_DELAY_EN adds LFSR-driven random read/write delays.
module ysyx_23060061_axil_sram
  import ysyx_23060061_axi_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];

  logic [RND_W-1:0] rnd_c;

`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
  ysyx_23060061_lfsr8 u_lfsr (
    .clk_i (clk),
    .rst_i (rst),
    .rnd_o (rnd_c)
  );
`else
  assign rnd_c = '0;
`endif

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE) >> 2);
  endfunction

  // ---------------- read path ----------------
  r_state_e         r_state_q, r_state_d;
  logic [31:0]      raddr_q, raddr_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;

  // Read next-state: accept address, count down latency, present data
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          raddr_d   = araddr;
          rcnt_d    = CNT_W'(RD_LAT) + CNT_W'(rnd_c);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          r_state_d = R_RESP;
          if (addr_err(raddr_q, BASE, 32'(DEPTH))) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = mem[word_idx(raddr_q)];
            rresp_d = RESP_OKAY;
          end
        end else begin
          rcnt_d = rcnt_q - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  // Read state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // ---------------- write path ----------------
  w_state_e         w_state_q, w_state_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             aw_got_q, aw_got_d;
  logic             w_got_q, w_got_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic             commit_c;
  logic             werr_c;
  logic             mem_we_c;

  assign werr_c = addr_err(waddr_q, BASE, 32'(DEPTH));

  // Write next-state: gather AW and W in any order, commit, respond
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    commit_c  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          waddr_d  = awaddr;
          aw_got_d = 1'b1;
        end
        if (wvalid && wready_q) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
          w_got_d = 1'b1;
        end
        if (aw_got_d && w_got_d) begin
          wcnt_d    = CNT_W'(rnd_c);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          commit_c  = 1'b1;
          bresp_d   = werr_c ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (bready) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_got_d;
    wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      wcnt_q    <= '0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  // Reset drops an in-flight commit; decode errors never touch memory
  assign mem_we_c = commit_c && !werr_c && !rst;

  // Byte-masked memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_axil_sram.sv
// Scoreboard bench for ysyx_23060061_axil_sram (default parameters).
module tb_ysyx_23060061_axil_sram;

  localparam int unsigned DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int unsigned RD_LAT = 1;

  logic        clk, rst;
  logic [31:0] araddr;  logic arvalid, arready;
  logic [31:0] rdata;   logic [1:0] rresp; logic rvalid, rready;
  logic [31:0] awaddr;  logic awvalid, awready;
  logic [31:0] wdata;   logic [3:0] wstrb; logic wvalid, wready;
  logic [1:0]  bresp;   logic bvalid, bready;

  ysyx_23060061_axil_sram #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

  rexp_t       rd_q[$];
  logic [1:0]  wr_q[$];
  logic [31:0] model [int unsigned];
  int          n_vec;
  int          n_miss;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (a > BASE + 32'(4*DEPTH) - 32'd4);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic check_lat(input string tag, input int lat);
`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
    check_eq(tag, 32'((lat >= int'(RD_LAT) + 1) && (lat <= int'(RD_LAT) + 8)), 32'd1);
`else
    check_eq(tag, 32'(lat), 32'(RD_LAT + 1));
`endif
  endtask

  // Starts and ends just after a falling edge
  task automatic do_read(input logic [31:0] a, input int hold, output int lat, output logic [31:0] got);
    rexp_t e;
    int n;
    if (addr_bad(a)) begin e.data = '0; e.resp = 2'b10; end
    else begin e.data = model[widx(a)]; e.resp = 2'b00; end
    rd_q.push_back(e);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check_eq("ar_timeout", 32'd1, 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 40) begin @(negedge clk); lat++; end
    e = rd_q.pop_front();
    got = rdata;
    check_eq("rdata", rdata, e.data);
    check_eq("rresp", 32'(rresp), 32'(e.resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("rvalid_hold", 32'(rvalid), 32'd1);
      check_eq("rdata_hold", rdata, e.data);
      check_eq("arready_busy", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_eq("rvalid_drop", 32'(rvalid), 32'd0);
    check_eq("arready_reopen", 32'(arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    logic [1:0] er;
    logic aw_hs, w_hs;
    bit aw_done, w_done;
    int cyc, lat;
    er = addr_bad(a) ? 2'b10 : 2'b00;
    wr_q.push_back(er);
    if (!addr_bad(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    awaddr = a; wdata = d; wstrb = s;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 60) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if (aw_done) check_eq("awready_hold", 32'(awready), 32'd0);
      if (w_done)  check_eq("wready_hold", 32'(wready), 32'd0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (cyc >= 60) check_eq("w_timeout", 32'd1, 32'd0);
    lat = 0;
    while (!bvalid && lat < 40) begin @(negedge clk); lat++; end
`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
    check_eq("b_lat", 32'((lat >= 1) && (lat <= 8)), 32'd1);
`else
    check_eq("b_lat", 32'(lat), 32'd1);
`endif
    check_eq("bresp", 32'(bresp), 32'(wr_q.pop_front()));
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_eq("bvalid_drop", 32'(bvalid), 32'd0);
    check_eq("awready_reopen", 32'(awready), 32'd1);
    check_eq("wready_reopen", 32'(wready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int lats[16];
    logic [31:0] got, a, old;
    bit all_eq;
    n_vec = 0; n_miss = 0;
    rst = 1'b1;
    araddr = '0; arvalid = 0; rready = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_rresp", 32'(rresp), 32'd0);
    check_eq("rst_bresp", 32'(bresp), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_arready", 32'(arready), 32'd1);
    check_eq("post_rst_awready", 32'(awready), 32'd1);
    check_eq("post_rst_wready", 32'(wready), 32'd1);

    // Basic word write and read
    do_write(BASE, 32'h0010_0093, 4'hF, 0, 0);
    do_read(BASE, 0, lat, got);
    check_lat("r_lat_word0", lat);
    check_eq("word0_val", got, 32'h0010_0093);

    // Partial write with W three cycles after AW
    do_write(BASE + 32'd4, 32'h1122_3344, 4'hF, 0, 0);
    do_write(BASE + 32'd4, 32'hDEAD_BEEF, 4'b0011, 0, 3);
    do_read(BASE + 32'd4, 0, lat, got);
    check_eq("word1_merge", got, 32'h1122_BEEF);

    // Decode errors
    do_read(BASE + 32'h1000, 0, lat, got);
    do_read(BASE + 32'd2, 0, lat, got);
    do_write(32'h7FFF_FFFC, 32'hCAFE_F00D, 4'hF, 0, 0);
    do_read(BASE, 0, lat, got);
    check_eq("word0_untouched", got, 32'h0010_0093);

    // Empty strobe, last word, W before AW
    do_write(BASE + 32'd4, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    do_read(BASE + 32'd4, 0, lat, got);
    do_write(BASE + 32'hFFC, 32'hA5A5_5A5A, 4'hF, 1, 1);
    do_read(BASE + 32'hFFC, 0, lat, got);
    do_write(BASE + 32'd8, 32'h0BAD_CAFE, 4'b1100, 2, 0);
    do_write(BASE + 32'd8, 32'h1357_9BDF, 4'b0110, 0, 0);
    do_read(BASE + 32'd8, 0, lat, got);

    // Master stalls rready for 5 cycles
    do_read(BASE + 32'd4, 5, lat, got);

    // Reset while the read is waiting
    araddr = BASE; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("rstw_arready", 32'(arready), 32'd0);
    check_eq("rstw_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstw_arready_after", 32'(arready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("rstw_no_rvalid", 32'(rvalid), 32'd0);
      @(negedge clk);
    end
    do_read(BASE, 0, lat, got);

`ifndef YSYX_23060061_SRAM_RAND_DELAY_EN
    // Read sampling the word in its write-commit cycle sees old data
    a = BASE + 32'd4;
    old = model[widx(a)];
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    awaddr = a; awvalid = 1'b1; wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check_eq("conc_rvalid", 32'(rvalid), 32'd1);
    check_eq("conc_rdata_old", rdata, old);
    check_eq("conc_bvalid", 32'(bvalid), 32'd1);
    check_eq("conc_bresp", 32'(bresp), 32'd0);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    model[widx(a)] = 32'h7777_8888;
    do_read(a, 0, lat, got);
`endif

    // Random full and partial writes with readback
    for (int i = 0; i < 6; i++) begin
      a = BASE + 32'(4 * $urandom_range(16, 63));
      do_write(a, $urandom, 4'hF, $urandom_range(0, 3), $urandom_range(0, 3));
      do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      do_read(a, $urandom_range(0, 2), lat, got);
    end

    // Back-to-back reads: latency profile
    for (int i = 0; i < 16; i++) begin
      do_read(BASE + 32'(4 * (i % 3)), 0, lat, got);
      lats[i] = lat;
      check_lat("r_lat_b2b", lat);
    end
    all_eq = 1;
    for (int i = 1; i < 16; i++) if (lats[i] != lats[0]) all_eq = 0;
`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
    check_eq("lat_varies", 32'(all_eq), 32'd0);
`else
    check_eq("lat_fixed", 32'(all_eq), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_axil_sram.md
YSYX_23060061_AXIL_SRAM -- requirements
Module: ysyx_23060061_axil_sram

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-003 SHALL have parameter RD_LAT, default 1, extra read wait cycles (0..15).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port araddr  input  32  read byte address.
REQ-007 SHALL have port arvalid  input  1  read address valid.
REQ-008 SHALL have port arready  output  1  read address accept.
REQ-009 SHALL have port rdata  output  32  read data.
REQ-010 SHALL have port rresp  output  2  read response.
REQ-011 SHALL have port rvalid  output  1  read data valid.
REQ-012 SHALL have port rready  input  1  master accepts read data.
REQ-013 SHALL have port awaddr  input  32  write byte address.
REQ-014 SHALL have port awvalid  input  1  write address valid.
REQ-015 SHALL have port awready  output  1  write address accept.
REQ-016 SHALL have port wdata  input  32  write data.
REQ-017 SHALL have port wstrb  input  4  byte enables, bit n covers wdata[8n+7:8n].
REQ-018 SHALL have port wvalid  input  1  write data valid.
REQ-019 SHALL have port wready  output  1  write data accept.
REQ-020 SHALL have port bresp  output  2  write response.
REQ-021 SHALL have port bvalid  output  1  write response valid.
REQ-022 SHALL have port bready  input  1  master accepts write response.

Function
REQ-023 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE.
REQ-024 AR handshake (arvalid&arready) SHALL latch araddr, load latency counter, enter R_WAIT.
REQ-025 rvalid SHALL rise exactly RD_LAT+1 cycles after the AR handshake cycle (RD_LAT=0 -> next cycle).
REQ-026 rdata/rresp SHALL be sampled on entry to R_RESP and held stable with rvalid until rvalid&rready; then R_IDLE, arready=1 the following cycle (no same-cycle re-accept).
REQ-027 Decode: index=(addr-BASE)>>2; addr[1:0]!=0 or index>=DEPTH or addr<BASE -> SLVERR (2'b10), rdata=0; otherwise OKAY (2'b00).
REQ-028 Write FSM SHALL capture AW and W independently; awready (wready) =1 until its channel handshakes, then 0 until B handshake.
REQ-029 When both AW and W captured (same or different cycles), write SHALL commit on the next cycle, updating only bytes with wstrb=1; bvalid=1 from that cycle.
REQ-030 wstrb=4'b0000 -> no memory change, bresp=OKAY; decode error -> no memory change, bresp=SLVERR.
REQ-031 bvalid/bresp SHALL hold until bvalid&bready; then awready=wready=1 the following cycle.
REQ-032 Read and write paths SHALL run concurrently; a read sampling the same word in the write commit cycle SHALL return pre-write data.

Reset
REQ-033 While rst=1: arready, awready, wready, rvalid, bvalid =0; rdata=0; rresp=bresp=2'b00; both FSMs idle; in-flight transactions discarded; memory contents retained (not reset).
REQ-034 First cycle after rst falls: arready=awready=wready=1.

Configuration
REQ-035 Macro YSYX_23060061_SRAM_RAND_DELAY_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset, steps every cycle) adds lfsr[2:0] cycles to read latency (latched at AR handshake) and delays write commit by lfsr[2:0] cycles (latched when both channels captured).
REQ-036 Macro undefined: fixed latencies per REQ-025/REQ-029, no LFSR logic present.

Structure
REQ-037 Shared package ysyx_23060061_axi_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the read/write FSM state encodings.
REQ-038 LFSR SHALL be sub-module ysyx_23060061_lfsr8, instantiated only under the macro.

Verification
REQ-039 mem[0]=32'h00100093, RD_LAT=1, read 32'h8000_0000, rready=1 -> rvalid 2 cycles after AR handshake, rdata=32'h00100093, rresp=00.
REQ-040 mem[1]=32'h11223344; AW 32'h8000_0004, W 3 cycles later 32'hDEADBEEF wstrb 4'b0011 -> bresp=00 one cycle after W handshake; read back 32'h1122BEEF.
REQ-041 Read 32'h8000_1000 (DEPTH=1024) and 32'h8000_0002 -> rresp=10, rdata=0; write 32'h7FFF_FFFC -> bresp=10, memory unchanged.
REQ-042 rready=0 for 5 cycles after rvalid -> rvalid/rdata stable, arready=0; handshake -> arready=1 next cycle.
REQ-043 rst pulsed while in R_WAIT -> rvalid never rises, arready=0 during reset, 1 after; memory word unchanged on re-read.
REQ-044 Macro defined, 16 back-to-back reads -> each latency in [RD_LAT+1, RD_LAT+8], not all equal; macro undefined -> all exactly RD_LAT+1.
